// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: takes one decoded instruction, reads its sources from a
// registered-read register file, resolves them against a writeback bypass and
// a 32-entry pending-write scoreboard, then presents the bundle to execute.
module operand_fetch_stage #(
    parameter int CTRL_W = 16,
    parameter int XLEN   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // decode side
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [4:0]        dec_rs1_i,
    input  logic [4:0]        dec_rs2_i,
    input  logic [4:0]        dec_rd_i,
    input  logic              dec_rd_wr_i,
    input  logic [CTRL_W-1:0] dec_ctrl_i,
    input  logic [XLEN-1:0]   dec_imm_i,
    input  logic [XLEN-1:0]   dec_pc_i,
    // register file read port (data returns one cycle after address)
    output logic [4:0]        rf_rs1_addr_o,
    output logic [4:0]        rf_rs2_addr_o,
    input  logic [XLEN-1:0]   rf_rs1_data_i,
    input  logic [XLEN-1:0]   rf_rs2_data_i,
    // writeback
    input  logic              wb_valid_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    // control
    input  logic              flush_i,
    // execute side
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   ex_op1_o,
    output logic [XLEN-1:0]   ex_op2_o,
    output logic [4:0]        ex_rd_o,
    output logic              ex_rd_wr_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [XLEN-1:0]   ex_pc_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        OUT     = 2'd3
    } state_t;

    // Decoded instruction as held while it moves through the stage.
    typedef struct packed {
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              rd_wr;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
    } instr_t;

    // Operand bundle handed to execute.
    typedef struct packed {
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [4:0]        rd;
        logic              rd_wr;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
    } bundle_t;

    state_t          state_q, state_d;
    instr_t          ins_q;
    bundle_t         ex_q;
    logic [31:0]     pend_q, pend_d;
    logic            byp1_q, byp2_q;
    logic [XLEN-1:0] bypd1_q, bypd2_q;

    logic [31:0]     wb_clr;
    logic [31:0]     pend_eff;
    logic            hazard;
    logic            byp1_hit, byp2_hit;
    logic            rd_tracked;
    logic            accept;
    logic            issue_go;
    logic            out_done;
    logic [XLEN-1:0] op1_res, op2_res;

    // Hazard view of the scoreboard: a writeback clearing an entry this cycle
    // already counts as resolved, the bypass supplies its data.
    always_comb begin
        wb_clr   = wb_valid_i ? (32'd1 << wb_rd_i) : 32'd0;
        pend_eff = pend_q & ~wb_clr;
        hazard   = ((ins_q.rs1 != 5'd0) && pend_eff[ins_q.rs1]) ||
                   ((ins_q.rs2 != 5'd0) && pend_eff[ins_q.rs2]) ||
                   (ins_q.rd_wr && (ins_q.rd != 5'd0) && pend_eff[ins_q.rd]);
        byp1_hit = wb_valid_i && (wb_rd_i == ins_q.rs1) && (ins_q.rs1 != 5'd0);
        byp2_hit = wb_valid_i && (wb_rd_i == ins_q.rs2) && (ins_q.rs2 != 5'd0);
        rd_tracked = ins_q.rd_wr && (ins_q.rd != 5'd0);
        accept   = (state_q == IDLE)  && dec_valid_i && !flush_i;
        issue_go = (state_q == ISSUE) && !hazard && !flush_i;
        out_done = (state_q == OUT)   && ex_ready_i && !flush_i;
    end

    // Operand resolution in CAPTURE: bypass beats the (stale) RF read, x0 is 0.
    always_comb begin
        op1_res = byp1_q ? bypd1_q : rf_rs1_data_i;
        op2_res = byp2_q ? bypd2_q : rf_rs2_data_i;
        if (ins_q.rs1 == 5'd0) op1_res = '0;
        if (ins_q.rs2 == 5'd0) op2_res = '0;
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (dec_valid_i) state_d = ISSUE;
            ISSUE:   if (!hazard)     state_d = CAPTURE;
            CAPTURE:                  state_d = OUT;
            OUT:     if (ex_ready_i)  state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Scoreboard update: clear on writeback, set in CAPTURE (set wins), and a
    // flushed OUT bundle releases its own entry so it is never orphaned.
    always_comb begin
        pend_d = pend_q;
        if (wb_valid_i) pend_d[wb_rd_i] = 1'b0;
        if ((state_q == CAPTURE) && !flush_i && rd_tracked) pend_d[ins_q.rd] = 1'b1;
        if ((state_q == OUT) && flush_i && rd_tracked)      pend_d[ins_q.rd] = 1'b0;
        pend_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    // Latch the decoded instruction on accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ins_q <= '0;
        end else if (accept) begin
            ins_q.rs1   <= dec_rs1_i;
            ins_q.rs2   <= dec_rs2_i;
            ins_q.rd    <= dec_rd_i;
            ins_q.rd_wr <= dec_rd_wr_i;
            ins_q.ctrl  <= dec_ctrl_i;
            ins_q.imm   <= dec_imm_i;
            ins_q.pc    <= dec_pc_i;
        end
    end

    // Bypass capture on the cycle the instruction leaves ISSUE; the RF read
    // issued that same cycle misses the concurrent write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byp1_q  <= 1'b0;
            byp2_q  <= 1'b0;
            bypd1_q <= '0;
            bypd2_q <= '0;
        end else if (flush_i || out_done) begin
            byp1_q <= 1'b0;
            byp2_q <= 1'b0;
        end else if (issue_go) begin
            byp1_q <= byp1_hit;
            byp2_q <= byp2_hit;
            if (byp1_hit) bypd1_q <= wb_data_i;
            if (byp2_hit) bypd2_q <= wb_data_i;
        end
    end

    // Output bundle register, loaded in CAPTURE and held through OUT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q <= '0;
        end else if ((state_q == CAPTURE) && !flush_i) begin
            ex_q.op1   <= op1_res;
            ex_q.op2   <= op2_res;
            ex_q.rd    <= ins_q.rd;
            ex_q.rd_wr <= ins_q.rd_wr;
            ex_q.ctrl  <= ins_q.ctrl;
            ex_q.imm   <= ins_q.imm;
            ex_q.pc    <= ins_q.pc;
        end
    end

    // Port outputs derived from state and registered bundle.
    always_comb begin
        dec_ready_o   = (state_q == IDLE);
        ex_valid_o    = (state_q == OUT);
        rf_rs1_addr_o = 5'd0;
        rf_rs2_addr_o = 5'd0;
        if ((state_q == ISSUE) || (state_q == CAPTURE)) begin
            rf_rs1_addr_o = ins_q.rs1;
            rf_rs2_addr_o = ins_q.rs2;
        end
        ex_op1_o   = ex_q.op1;
        ex_op2_o   = ex_q.op2;
        ex_rd_o    = ex_q.rd;
        ex_rd_wr_o = ex_q.rd_wr;
        ex_ctrl_o  = ex_q.ctrl;
        ex_imm_o   = ex_q.imm;
        ex_pc_o    = ex_q.pc;
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: architectural register model predicts each
// bundle, a monitor compares every cycle the bundle is presented.
module tb_operand_fetch_stage;
    localparam int CTRL_W = 16;
    localparam int XLEN   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_i;
    logic              dec_valid_i, dec_ready_o;
    logic [4:0]        dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic              dec_rd_wr_i;
    logic [CTRL_W-1:0] dec_ctrl_i;
    logic [XLEN-1:0]   dec_imm_i, dec_pc_i;
    logic [4:0]        rf_rs1_addr_o, rf_rs2_addr_o;
    logic [XLEN-1:0]   rf_rs1_data_i, rf_rs2_data_i;
    logic              wb_valid_i;
    logic [4:0]        wb_rd_i;
    logic [XLEN-1:0]   wb_data_i;
    logic              flush_i;
    logic              ex_valid_o, ex_ready_i;
    logic [XLEN-1:0]   ex_op1_o, ex_op2_o;
    logic [4:0]        ex_rd_o;
    logic              ex_rd_wr_o;
    logic [CTRL_W-1:0] ex_ctrl_o;
    logic [XLEN-1:0]   ex_imm_o, ex_pc_o;

    operand_fetch_stage #(.CTRL_W(CTRL_W), .XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
        .dec_rd_wr_i(dec_rd_wr_i), .dec_ctrl_i(dec_ctrl_i),
        .dec_imm_i(dec_imm_i), .dec_pc_i(dec_pc_i),
        .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o), .ex_rd_o(ex_rd_o),
        .ex_rd_wr_o(ex_rd_wr_o), .ex_ctrl_o(ex_ctrl_o),
        .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o)
    );

    typedef struct {
        logic [31:0] op1, op2, imm, pc, wbdata;
        logic [15:0] ctrl;
        logic [4:0]  rd;
        logic        rd_wr;
        bit          do_wb;
        int          lat;
    } exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t expq[$];
    wb_t  wbq[$];
    logic [31:0] arch [32];
    int wb_lo = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: registered read, write on writeback. x0 holds
    // junk so the stage must force it to zero itself.
    logic [31:0] rf_mem [32];
    logic        init_rf;
    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'hDEAD_BEEF;
        if (i == 5) return 32'h0000_1234;
        return 32'h1000_0000 + 32'(i) * 32'h111;
    endfunction

    always @(posedge clk) begin
        if (init_rf) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
        end else if (wb_valid_i) begin
            rf_mem[wb_rd_i] <= wb_data_i;
        end
        rf_rs1_data_i <= rf_mem[rf_rs1_addr_o];
        rf_rs2_data_i <= rf_mem[rf_rs2_addr_o];
    end

    // Writeback sources: an in-order execute model and directed stimulus.
    logic        wbp_valid, wbs_valid;
    logic [4:0]  wbp_rd, wbs_rd;
    logic [31:0] wbp_data, wbs_data;
    assign wb_valid_i = wbp_valid | wbs_valid;
    assign wb_rd_i    = wbs_valid ? wbs_rd : wbp_rd;
    assign wb_data_i  = wbs_valid ? wbs_data : wbp_data;

    initial begin
        int dly;
        wb_t j;
        dly = -1;
        wbp_valid = 1'b0; wbp_rd = '0; wbp_data = '0;
        forever begin
            @(posedge clk); #1;
            wbp_valid = 1'b0;
            if (wbq.size() != 0) begin
                if (dly < 0) dly = $urandom_range(wb_lo, wb_lo + 3);
                if (dly == 0) begin
                    j = wbq.pop_front();
                    wbp_valid = 1'b1; wbp_rd = j.rd; wbp_data = j.data;
                    dly = -1;
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: compares the presented bundle every cycle, retires on handshake.
    initial begin
        exp_t h;
        bit prev_vld;
        int acc_cyc;
        prev_vld = 1'b0;
        acc_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_vld = 1'b0;
                continue;
            end
            if (dec_valid_i && dec_ready_o) acc_cyc = cyc;
            if (ex_valid_o) begin
                if (expq.size() == 0) begin
                    fail_now("expected_bundle");
                end else begin
                    h = expq[0];
                    if (!prev_vld && h.lat >= 0) chk("latency", 64'(cyc - acc_cyc), 64'(h.lat));
                    chk("op1", ex_op1_o, h.op1);
                    chk("op2", ex_op2_o, h.op2);
                    chk("rd", ex_rd_o, h.rd);
                    chk("rd_wr", ex_rd_wr_o, h.rd_wr);
                    chk("ctrl", ex_ctrl_o, h.ctrl);
                    chk("imm", ex_imm_o, h.imm);
                    chk("pc", ex_pc_o, h.pc);
                    chk("dec_ready_busy", dec_ready_o, 1'b0);
                    if (flush_i) begin
                        h = expq.pop_front();
                    end else if (ex_ready_i) begin
                        h = expq.pop_front();
                        if (h.do_wb && h.rd_wr && h.rd != 5'd0) wbq.push_back('{h.rd, h.wbdata});
                    end
                end
            end
            prev_vld = ex_valid_o;
        end
    end

    // Issue one instruction; its expected bundle comes from the architectural
    // register values left by all older instructions.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rd_wr, input bit do_wb, input bit push, input int lat);
        exp_t e;
        bit ok;
        e.op1 = (rs1 == 5'd0) ? 32'd0 : arch[rs1];
        e.op2 = (rs2 == 5'd0) ? 32'd0 : arch[rs2];
        e.imm = $urandom; e.pc = $urandom; e.ctrl = 16'($urandom);
        e.wbdata = $urandom; e.rd = rd; e.rd_wr = rd_wr; e.do_wb = do_wb; e.lat = lat;
        if (push) expq.push_back(e);
        if (do_wb && rd_wr && rd != 5'd0) arch[rd] = e.wbdata;
        @(posedge clk); #1;
        dec_valid_i = 1'b1; dec_rs1_i = rs1; dec_rs2_i = rs2; dec_rd_i = rd;
        dec_rd_wr_i = rd_wr; dec_ctrl_i = e.ctrl; dec_imm_i = e.imm; dec_pc_i = e.pc;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (dec_ready_o) ok = 1'b1;
        end
        if (!ok) fail_now("accept");
        @(posedge clk); #1;
        dec_valid_i = 1'b0;
    endtask

    task automatic wait_out();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (ex_valid_o) ok = 1'b1;
        end
        if (!ok) fail_now("ex_valid");
    endtask

    task automatic finish_out(input int bp, input bit flush);
        repeat (bp + 1) @(posedge clk);
        #1;
        if (flush) begin
            flush_i = 1'b1;
            ex_ready_i = 1'($urandom_range(0, 1));
        end else begin
            ex_ready_i = 1'b1;
        end
        @(posedge clk); #1;
        flush_i = 1'b0; ex_ready_i = 1'b0;
        @(negedge clk);
        chk("valid_after_out", ex_valid_o, 1'b0);
        chk("ready_after_out", dec_ready_o, 1'b1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && wbq.size() != 0; n++) @(posedge clk);
        if (wbq.size() != 0) fail_now("wb_drain");
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old9;
        logic [4:0] r1, r2, rd;
        int mode;
        rst_i = 1'b1; init_rf = 1'b1;
        dec_valid_i = 1'b0; dec_rs1_i = '0; dec_rs2_i = '0; dec_rd_i = '0; dec_rd_wr_i = 1'b0;
        dec_ctrl_i = '0; dec_imm_i = '0; dec_pc_i = '0;
        flush_i = 1'b0; ex_ready_i = 1'b0;
        wbs_valid = 1'b0; wbs_rd = '0; wbs_data = '0;
        for (int i = 0; i < 32; i++) arch[i] = (i == 0) ? 32'd0 : init_val(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dec_ready", dec_ready_o, 1'b1);
        chk("rst_ex_valid", ex_valid_o, 1'b0);
        chk("rst_rf_addr", {rf_rs1_addr_o, rf_rs2_addr_o}, 10'd0);
        chk("rst_ex_data", {ex_op1_o, ex_op2_o}, 64'd0);
        chk("rst_ex_ctl", {ex_rd_o, ex_rd_wr_o, ex_ctrl_o}, 22'd0);
        chk("rst_ex_imm_pc", {ex_imm_o, ex_pc_o}, 64'd0);
        rst_i = 1'b0; init_rf = 1'b0;

        // No hazard: x5 -> op1, x0 -> op2, sets pend[6]; execute write held back.
        issue(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 3);
        arch[6] = 32'hCAFE;
        wait_out();
        finish_out(0, 1'b0);

        // RAW on x6: writeback in the 4th ISSUE cycle, delivered by bypass.
        issue(5'd6, 5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 6);
        repeat (3) begin @(posedge clk); #1; end
        wbs_valid = 1'b1; wbs_rd = 5'd6; wbs_data = 32'hCAFE;
        @(posedge clk); #1;
        wbs_valid = 1'b0;
        wait_out();
        finish_out(5, 1'b0);
        drain();

        // Flush in OUT releases pend[7]: a reader of x7 does not stall.
        issue(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 3);
        wait_out();
        finish_out(1, 1'b1);
        issue(5'd7, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 3);
        wait_out();
        finish_out(0, 1'b0);

        // Flush in ISSUE: back to IDLE, rd=10 never becomes pending.
        issue(5'd1, 5'd1, 5'd10, 1'b1, 1'b0, 1'b0, -1);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("issue_flush_idle", dec_ready_o, 1'b1);
        chk("issue_flush_valid", ex_valid_o, 1'b0);
        issue(5'd10, 5'd10, 5'd0, 1'b0, 1'b0, 1'b1, 3);
        wait_out();
        finish_out(0, 1'b0);

        // Set and clear of pend[9] in the same cycle: set must win.
        issue(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 3);
        wait_out();
        finish_out(0, 1'b0);
        drain();
        old9 = arch[9];
        issue(5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 3);
        @(posedge clk); #1;
        wbs_valid = 1'b1; wbs_rd = 5'd9; wbs_data = old9;
        @(posedge clk); #1;
        wbs_valid = 1'b0;
        wait_out();
        wb_lo = 6;
        finish_out(0, 1'b0);
        issue(5'd9, 5'd0, 5'd11, 1'b0, 1'b0, 1'b1, -1);
        wait_out();
        finish_out(0, 1'b0);
        drain();
        wb_lo = 0;

        // rd=0 with rd_wr: x0 never pending and always reads as zero.
        issue(5'd0, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 3);
        wait_out();
        finish_out(0, 1'b0);
        issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3);
        wait_out();
        finish_out(0, 1'b0);

        // Randomized traffic over a small register window to force hazards.
        for (int k = 0; k < 150; k++) begin
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            mode = $urandom_range(0, 99);
            if (mode < 5) begin
                issue(r1, r2, rd, 1'($urandom_range(0, 1)), 1'b0, 1'b0, -1);
                flush_i = 1'b1;
                @(posedge clk); #1;
                flush_i = 1'b0;
            end else if (mode < 13) begin
                issue(r1, r2, rd, 1'($urandom_range(0, 1)), 1'b0, 1'b1, -1);
                wait_out();
                finish_out($urandom_range(0, 3), 1'b1);
            end else begin
                issue(r1, r2, rd, 1'($urandom_range(0, 1)), 1'b1, 1'b1, -1);
                wait_out();
                finish_out($urandom_range(0, 3), 1'b0);
            end
        end
        drain();

        // Asynchronous reset in CAPTURE clears outputs and the scoreboard.
        issue(5'd3, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 3);
        wait_out();
        finish_out(0, 1'b0);
        issue(5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0, -1);
        @(posedge clk); #3;
        rst_i = 1'b1;
        #1;
        chk("arst_dec_ready", dec_ready_o, 1'b1);
        chk("arst_ex_valid", ex_valid_o, 1'b0);
        chk("arst_rf_addr", {rf_rs1_addr_o, rf_rs2_addr_o}, 10'd0);
        chk("arst_ex_data", {ex_op1_o, ex_op2_o}, 64'd0);
        chk("arst_ex_ctl", {ex_rd_o, ex_rd_wr_o, ex_ctrl_o}, 22'd0);
        chk("arst_ex_imm_pc", {ex_imm_o, ex_pc_o}, 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        issue(5'd9, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1, 3);
        wait_out();
        finish_out(0, 1'b0);
        chk("queue_empty", 64'(expq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
